// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (DrawX/DrawY, syncs, blank) from a 50 MHz clock with a 25 MHz pixel enable.
// Optional macro VGA_FRAME_COUNT_EN adds a 16-bit frame_count output.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 0
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       pixel_ce,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
  , output logic [15:0] frame_count
`endif
);
  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  logic       pce_q, pce_d, vclk_q, vclk_d, ls_q, ls_d, fs_q, fs_d, h_wrap, v_wrap;
  logic [9:0] h_q, h_d, v_q, v_d;
  // Each stage holds {hs_n, vs_n, blank_n}; stage 0 decodes the next count so outputs stay registered.
  logic [2:0] stg_q [0:SYNC_DELAY];
  logic [2:0] stg_d [0:SYNC_DELAY];
  always_comb begin
    h_wrap   = h_q == H_LAST;
    v_wrap   = v_q == V_LAST;
    pce_d    = ~pce_q;
    vclk_d   = ~pce_q;
    h_d      = pce_q ? (h_wrap ? 10'd0 : h_q + 10'd1) : h_q;
    v_d      = (pce_q && h_wrap) ? (v_wrap ? 10'd0 : v_q + 10'd1) : v_q;
    ls_d     = pce_d && h_d == 10'd0;
    fs_d     = ls_d && v_d == 10'd0;
    stg_d[0] = {!(h_d >= HS_BEG && h_d < HS_END), !(v_d >= VS_BEG && v_d < VS_END),
                h_d < H_VIS && v_d < V_VIS};
    for (int i = 1; i <= SYNC_DELAY; i++) stg_d[i] = pce_q ? stg_q[i-1] : stg_q[i];
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pce_q  <= 1'b0;
      vclk_q <= 1'b0;
      h_q    <= 10'd0;
      v_q    <= 10'd0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
      for (int i = 0; i <= SYNC_DELAY; i++) stg_q[i] <= 3'b110;
    end else begin
      pce_q  <= pce_d;
      vclk_q <= vclk_d;
      h_q    <= h_d;
      v_q    <= v_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
      stg_q  <= stg_d;
    end
  end
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] fc_q, fc_d;
  always_comb fc_d = (pce_q && h_wrap && v_wrap) ? fc_q + 16'd1 : fc_q;
  always_ff @(posedge Clk) fc_q <= Reset ? 16'd0 : fc_d;
  assign frame_count = fc_q;
`endif
  assign pixel_ce    = pce_q;
  assign VGA_CLK     = vclk_q;
  assign {VGA_HS, VGA_VS, VGA_BLANK_N} = stg_q[SYNC_DELAY];
  assign VGA_SYNC_N  = 1'b0;
  assign DrawX       = h_q;
  assign DrawY       = v_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen with default, reduced-size and SYNC_DELAY=2 instances.
module tb_vga_timing_gen;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int total = 0;
  int passed = 0;
  always #5 Clk = ~Clk;
  logic a_ce, a_vclk, a_hs, a_vs, a_bl, a_sn, a_ls, a_fs;
  logic b_ce, b_vclk, b_hs, b_vs, b_bl, b_sn, b_ls, b_fs;
  logic c_ce, c_vclk, c_hs, c_vs, c_bl, c_sn, c_ls, c_fs;
  logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] a_fc, b_fc, c_fc;
`endif
  vga_timing_gen u_a (
    .Clk(Clk), .Reset(Reset), .pixel_ce(a_ce), .VGA_CLK(a_vclk), .VGA_HS(a_hs), .VGA_VS(a_vs),
    .VGA_BLANK_N(a_bl), .VGA_SYNC_N(a_sn), .DrawX(a_x), .DrawY(a_y), .line_start(a_ls), .frame_start(a_fs)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(a_fc)
`endif
  );
  // 30 x 15 raster: one frame is 900 Clk, VS low on rows 10..11.
  vga_timing_gen #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
    .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) u_b (
    .Clk(Clk), .Reset(Reset), .pixel_ce(b_ce), .VGA_CLK(b_vclk), .VGA_HS(b_hs), .VGA_VS(b_vs),
    .VGA_BLANK_N(b_bl), .VGA_SYNC_N(b_sn), .DrawX(b_x), .DrawY(b_y), .line_start(b_ls), .frame_start(b_fs)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(b_fc)
`endif
  );
  vga_timing_gen #(.SYNC_DELAY(2)) u_c (
    .Clk(Clk), .Reset(Reset), .pixel_ce(c_ce), .VGA_CLK(c_vclk), .VGA_HS(c_hs), .VGA_VS(c_vs),
    .VGA_BLANK_N(c_bl), .VGA_SYNC_N(c_sn), .DrawX(c_x), .DrawY(c_y), .line_start(c_ls), .frame_start(c_fs)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(c_fc)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask
  function automatic logic sig(input int sel);
    case (sel)
      0: return a_hs;
      1: return a_bl;
      2: return b_vs;
      3: return b_fs;
      4: return c_hs;
      5: return c_bl;
      default: return 1'bx;
    endcase
  endfunction
  task automatic wait_until(input int sel, input logic val, input int lim, output int n);
    n = 0;
    while (sig(sel) !== val && n < lim) begin
      @(negedge Clk);
      n++;
    end
    chk($sformatf("wait_sel%0d", sel), sig(sel), val);
  endtask
  initial begin
    int n, m, bl_tot, bl_bad, ls_cnt, fs_cnt;
    repeat (5) @(negedge Clk);
    chk("rst_hs", a_hs, 1);
    chk("rst_vs", a_vs, 1);
    chk("rst_blank", a_bl, 0);
    chk("rst_x", a_x, 0);
    chk("rst_y", a_y, 0);
    chk("rst_ce", a_ce, 0);
    chk("rst_vclk", a_vclk, 0);
    chk("rst_ls", a_ls, 0);
    chk("rst_fs", a_fs, 0);
    chk("sync_n", a_sn, 0);
    chk("rst_d2_hs", c_hs, 1);
    chk("rst_d2_blank", c_bl, 0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("first_ce", a_ce, 1);
    chk("first_ls", a_ls, 1);
    chk("first_fs", a_fs, 1);
    chk("first_blank", a_bl, 1);
    chk("first_d2_blank", c_bl, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("ce_seq", a_ce, i == 1);
      chk("fs_single", a_fs, 0);
    end
    wait_until(1, 1'b0, 4000, n);
    chk("blank_fall_x", a_x, 640);
    chk("blank_fall_y", a_y, 0);
    wait_until(0, 1'b0, 4000, n);
    chk("hs_fall_x", a_x, 656);
    wait_until(0, 1'b1, 4000, n);
    chk("hs_low_clk", n, 192);
    wait_until(0, 1'b0, 4000, m);
    chk("hs_period", n + m, 1600);
    chk("hs_fall2_x", a_x, 656);
    chk("hs_fall2_y", a_y, 1);
    wait_until(1, 1'b1, 4000, n);
    chk("blank_rise_x", a_x, 0);
    chk("blank_rise_y", a_y, 2);
    wait_until(1, 1'b0, 4000, n);
    chk("blank_high_clk", n, 1280);
    chk("blank_fall2_x", a_x, 640);
    wait_until(5, 1'b0, 100, n);
    chk("d2_blank_fall_x", c_x, 642);
    wait_until(4, 1'b0, 100, n);
    chk("d2_hs_fall_x", c_x, 658);
    wait_until(3, 1'b1, 1000, n);
    bl_tot = 0;
    bl_bad = 0;
    ls_cnt = 0;
    fs_cnt = 0;
    for (int i = 0; i < 900; i++) begin
      @(negedge Clk);
      if (b_bl) begin
        bl_tot++;
        if (b_y >= 8) bl_bad++;
      end
      if (b_ls) ls_cnt++;
      if (b_fs) fs_cnt++;
    end
    chk("frame_period_fs", b_fs, 1);
    chk("frame_fs_count", fs_cnt, 1);
    chk("frame_ls_count", ls_cnt, 15);
    chk("frame_blank_clk", bl_tot, 256);
    chk("vblank_blank_clk", bl_bad, 0);
    wait_until(2, 1'b0, 1000, n);
    chk("vs_fall_y", b_y, 10);
    chk("vs_fall_x", b_x, 0);
    wait_until(2, 1'b1, 1000, n);
    chk("vs_low_clk", n, 120);
    chk("vs_rise_y", b_y, 12);
    n = 0;
    while (!(b_y == 5 && b_x == 10) && n < 1000) begin
      @(negedge Clk);
      n++;
    end
    chk("seek_mid_frame", n < 1000, 1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("midrst_x", b_x, 0);
    chk("midrst_y", b_y, 0);
    chk("midrst_hs", b_hs, 1);
    chk("midrst_vs", b_vs, 1);
    chk("midrst_blank", b_bl, 0);
    chk("midrst_fs", b_fs, 0);
    @(negedge Clk);
    chk("midrst_first_fs", b_fs, 1);
    chk("midrst_first_ls", b_ls, 1);
    @(negedge Clk);
    wait_until(3, 1'b1, 1000, n);
    chk("midrst_fs_period", n + 1, 900);
`ifdef VGA_FRAME_COUNT_EN
    chk("fc_one", b_fc, 1);
    repeat (2) begin
      @(negedge Clk);
      wait_until(3, 1'b1, 1000, n);
    end
    chk("fc_three", b_fc, 3);
    force u_b.fc_q = 16'hFFFF;
    @(negedge Clk);
    release u_b.fc_q;
    wait_until(3, 1'b1, 1000, n);
    chk("fc_wrap", b_fc, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
